mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Shares one combinational array multiplier (M_WID x Q_WID, unregistered) among NREQ requesters.
- Round-robin grant; operands registered into the multiplier inputs; product sampled after a fixed multicycle settle window; result returned with requester ID over a valid/ready handshake.
- Sits between the client blocks and the single multiplier instance, which it drives directly.

Parameters:
NREQ, 4, number of requesters (2..16)
M_WID, 32, multiplicand width
Q_WID, 32, multiplier width
MC_CYCLES, 2, settle cycles allowed for the combinational multiplier (>=1)
IDW, max(1,clog2(NREQ)), requester ID width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_m  in  NREQ*M_WID  packed multiplicands, requester k at [k*M_WID +: M_WID]
req_q  in  NREQ*Q_WID  packed multipliers, same packing
mul_m  out  M_WID  registered operand to multiplier
mul_q  out  Q_WID  registered operand to multiplier
mul_product  in  M_WID+Q_WID  multiplier result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of requester owning the result
rsp_product  out  M_WID+Q_WID  registered product
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst high at edge): state=IDLE, ptr=0, cnt=0, mul_m=0, mul_q=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0. req_ready=0 while rst high.
- Reset mid-operation aborts the transaction: no response, no partial result visible.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant g = first k with req_valid[k]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - On an edge with req_valid[g]&req_ready[g] (cycle T): mul_m<=req_m[g], mul_q<=req_q[g], rsp_id<=g, cnt<=MC_CYCLES-1, go to CALC.
  - No request valid: stay in IDLE. req_ready=0 and mul_m/mul_q hold their values.
- CALC:
  - Operands are stable on mul_m/mul_q from T+1.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_product<=mul_product, rsp_valid<=1, go to RESP.
  - Result is therefore visible at T+MC_CYCLES+1. With MC_CYCLES=1 it is visible at T+2.
  - req_ready=0 throughout CALC.
- RESP:
  - rsp_valid, rsp_id and rsp_product are held stable until rsp_valid&rsp_ready.
  - On handshake: rsp_valid<=0, ptr<=(rsp_id==NREQ-1)?0:rsp_id+1, go to IDLE.
  - req_ready=0 throughout RESP; no new grant is given in the handshake cycle.
  - rsp_ready held high gives exactly one rsp_valid cycle.
- Throughput: at most one operation per MC_CYCLES+2 cycles.
- Fairness: a continuously asserted requester is served within NREQ operations.
- Requester semantics:
  - Deasserting req_valid before grant is legal and carries no commitment.
  - After acceptance the requester may change req_m/req_q freely, because operands are registered.
- Arithmetic: product is unsigned, full width M_WID+Q_WID, no truncation. The block never modifies mul_product.
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
- Single request: NREQ=4, MC_CYCLES=2, req0 m=0xFFFFFFFF q=0xFFFFFFFF accepted at T -> rsp_valid at T+3, rsp_id=0, rsp_product=0xFFFFFFFE00000001, busy high T+1..handshake.
- Round-robin: all four req_valid held high, rsp_ready=1, operands m=k+1 q=10 -> responses in order id 0,1,2,3,0 with products 10,20,30,40,10; each grant exactly 4 cycles apart.
- Wrap and skip: ptr=3 (after serving id 2), only req1 and req3 valid -> id 3 served first, then id 1; ptr then becomes 2.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, m=7 q=6 -> rsp_product=42 and rsp_id held stable; req_ready stays 0; no second grant until the cycle after handshake.
- Operand change after accept: req2 m=3 q=5 accepted, then req_m/req_q changed to 0 the next cycle -> rsp_product=15.
- Reset mid-CALC: rst pulsed one cycle at T+1 -> rsp_valid never rises for that request; all outputs 0; ptr=0; next request from req1 is served normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among NREQ requesters.
// Operands are registered, the product is sampled after a fixed settle window and returned with its ID.
module mult_share_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned M_WID     = 32,
    parameter int unsigned Q_WID     = 32,
    parameter int unsigned MC_CYCLES = 2,
    localparam int unsigned IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*M_WID-1:0]    req_m,
    input  logic [NREQ*Q_WID-1:0]    req_q,
    output logic [M_WID-1:0]         mul_m,
    output logic [Q_WID-1:0]         mul_q,
    input  logic [M_WID+Q_WID-1:0]   mul_product,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [M_WID+Q_WID-1:0]   rsp_product,
    output logic                     busy
);

    localparam int unsigned CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     scan_idx;
    logic [M_WID-1:0] sel_m;
    logic [Q_WID-1:0] sel_q;
    logic             accept;
    logic             rsp_fire;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(i);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_m = req_m[int'(grant_idx)*M_WID +: M_WID];
        sel_q = req_q[int'(grant_idx)*Q_WID +: Q_WID];
    end

    assign accept   = (state_q == StIdle) && grant_found;
    assign rsp_fire = (state_q == StResp) && rsp_ready;

    always_comb begin
        req_ready = '0;
        if (!rst && accept) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (grant_found) state_d = StCalc;
            StCalc: if (cnt_q == '0) state_d = StResp;
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            mul_m       <= '0;
            mul_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            if (accept) begin
                mul_m  <= sel_m;
                mul_q  <= sel_q;
                rsp_id <= grant_idx;
                cnt_q  <= CNT_W'(MC_CYCLES - 1);
            end
            if (state_q == StCalc) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    rsp_product <= mul_product;
                    rsp_valid   <= 1'b1;
                end
            end
            if (rsp_fire) begin
                rsp_valid <= 1'b0;
                ptr_q     <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule
